fp_div_core: RTL and testbench



---
 rtl/fp_div_pkg.sv | 29 ++
 rtl/fp_div_if.sv | 26 ++
 rtl/fp_round_pack.sv | 45 ++++
 rtl/fp_div_core.sv | 161 ++++++++++++++++
 tb/tb_fp_div_core.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the single-precision divide core.
package fp_div_pkg;

  localparam int QBITS = 26;
  localparam int CNT_W = $clog2(QBITS);
  localparam logic signed [9:0] BIAS    = 10'sd127;
  localparam logic signed [9:0] EXP_MAX = 10'sd255;
  localparam logic [31:0]       QNAN    = 32'hFFC0_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    PACK = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    EXC_DIVZ = 2'b00,
    EXC_OVF  = 2'b01,
    EXC_UNF  = 2'b10,
    EXC_INV  = 2'b11
  } exc_t;

  // Subnormal encodings are flushed rather than divided.
  function automatic logic is_denormal(input logic [31:0] x);
    return (x[30:23] == 8'd0) && (x[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/fp_div_if.sv
// Request/result bundle between the special-operand checker side and the divide core.
// Handshake: start is a request sampled only when the core is idle and not in its
// done cycle; done is a one-cycle pulse that qualifies quotient/exception/exc_flag.
interface fp_div_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        chk_valid;
  logic [31:0] chk_result;
  logic [1:0]  chk_exception;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [1:0]  exception;
  logic        exc_flag;

  modport master (
    output start, a, b, chk_valid, chk_result, chk_exception,
    input  busy, done, quotient, exception, exc_flag
  );

  modport slave (
    input  start, a, b, chk_valid, chk_result, chk_exception,
    output busy, done, quotient, exception, exc_flag
  );
endinterface

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even, exponent range check and IEEE-754 packing of a normalized quotient.
module fp_round_pack
  import fp_div_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] e,
  input  logic [23:0]       mant,
  input  logic              g,
  input  logic              s,
  output logic [31:0]       word,
  output logic [1:0]        exception,
  output logic              exc_flag
);

  logic              round_up;
  logic [24:0]       mant_sum;
  logic [23:0]       mant_r;
  logic signed [9:0] e_r;

  always_comb begin
    round_up = g & (s | mant[0]);
    mant_sum = {1'b0, mant} + {24'd0, round_up};
    mant_r   = mant_sum[23:0];
    e_r      = e;
    // Rounding 1.111..1 up carries into the next binade.
    if (mant_sum[24]) begin
      mant_r = 24'h80_0000;
      e_r    = e + 10'sd1;
    end

    word      = {sign, e_r[7:0], mant_r[22:0]};
    exception = EXC_DIVZ;
    exc_flag  = 1'b0;
    if (e_r >= EXP_MAX) begin
      word      = {sign, 8'hFF, 23'd0};
      exception = EXC_OVF;
      exc_flag  = 1'b1;
    end else if (e_r <= 10'sd0) begin
      word      = {sign, 31'd0};
      exception = EXC_UNF;
      exc_flag  = 1'b1;
    end
  end

endmodule

// File: rtl/fp_div_core.sv
// Sequential single-precision divider: restoring mantissa division, normalize,
// round-to-nearest-even and pack; special operands bypass with the checker's verdict.
module fp_div_core
  import fp_div_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  fp_div_if.slave   bus,
  output state_t    dbg_state
);

  state_t state, state_next;

  logic              sign_q;
  logic [23:0]       mb_q;
  logic [24:0]       rem_q;
  logic [QBITS-1:0]  q_q;
  logic signed [9:0] e_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [23:0]       mant_q;
  logic              g_q;
  logic              s_q;

  logic              done_q;
  logic [31:0]       quotient_q;
  logic [1:0]        exception_q;
  logic              exc_flag_q;

  logic              accept;
  logic              den_a;
  logic              den_b;
  logic              go_div;
  logic              q_bit;
  logic [24:0]       rem_sub;
  logic [24:0]       rem_step;

  logic [31:0]       pk_word;
  logic [1:0]        pk_exc;
  logic              pk_flag;

  // The done cycle is spent in IDLE, so it must be excluded explicitly.
  assign accept = (state == IDLE) && bus.start && !done_q;
  assign den_a  = is_denormal(bus.a);
  assign den_b  = is_denormal(bus.b);
  assign go_div = accept && bus.chk_valid && !den_a && !den_b;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (go_div) state_next = DIV;
      DIV:     if (cnt_q == '0) state_next = NORM;
      NORM:    state_next = PACK;
      PACK:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    q_bit    = (rem_q >= {1'b0, mb_q});
    rem_sub  = q_bit ? (rem_q - {1'b0, mb_q}) : rem_q;
    // rem_sub < mb_q < 2^24, so the shift never loses a bit.
    rem_step = {rem_sub[23:0], 1'b0};
  end

  fp_round_pack u_round_pack (
    .sign      (sign_q),
    .e         (e_q),
    .mant      (mant_q),
    .g         (g_q),
    .s         (s_q),
    .word      (pk_word),
    .exception (pk_exc),
    .exc_flag  (pk_flag)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sign_q      <= 1'b0;
      mb_q        <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      e_q         <= '0;
      cnt_q       <= '0;
      mant_q      <= '0;
      g_q         <= 1'b0;
      s_q         <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      exception_q <= EXC_DIVZ;
      exc_flag_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (!bus.chk_valid) begin
              done_q      <= 1'b1;
              quotient_q  <= bus.chk_result;
              exception_q <= bus.chk_exception;
              exc_flag_q  <= 1'b1;
            end else if (den_b) begin
              done_q      <= 1'b1;
              quotient_q  <= QNAN;
              exception_q <= EXC_DIVZ;
              exc_flag_q  <= 1'b1;
            end else if (den_a) begin
              done_q      <= 1'b1;
              quotient_q  <= {bus.a[31] ^ bus.b[31], 31'd0};
              exception_q <= EXC_DIVZ;
              exc_flag_q  <= 1'b0;
            end else begin
              sign_q <= bus.a[31] ^ bus.b[31];
              mb_q   <= {1'b1, bus.b[22:0]};
              rem_q  <= {2'b01, bus.a[22:0]};
              q_q    <= '0;
              e_q    <= $signed({2'b00, bus.a[30:23]}) - $signed({2'b00, bus.b[30:23]}) + BIAS;
              cnt_q  <= CNT_W'(QBITS - 1);
            end
          end
        end
        DIV: begin
          q_q   <= {q_q[QBITS-2:0], q_bit};
          rem_q <= rem_step;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        NORM: begin
          if (q_q[QBITS-1]) begin
            mant_q <= q_q[QBITS-1:2];
            g_q    <= q_q[1];
            s_q    <= q_q[0] | (rem_q != '0);
          end else begin
            mant_q <= q_q[QBITS-2:1];
            g_q    <= q_q[0];
            s_q    <= (rem_q != '0);
            e_q    <= e_q - 10'sd1;
          end
        end
        PACK: begin
          done_q      <= 1'b1;
          quotient_q  <= pk_word;
          exception_q <= pk_exc;
          exc_flag_q  <= pk_flag;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE) || done_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.exception = exception_q;
  assign bus.exc_flag  = exc_flag_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_fp_div_core.sv
// Directed bench for fp_div_core: reset state, normal and special paths, flushes,
// range exceptions, start-in-done-cycle and mid-operation reset.
module tb_fp_div_core;
  import fp_div_pkg::*;

  logic   clk = 1'b0;
  logic   reset;
  state_t dbg_state;
  int     passed = 0;
  int     total  = 0;
  int     early_done;

  fp_div_if bus ();

  fp_div_core dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) passed++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, want);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cv, input logic [31:0] cr, input logic [1:0] ce,
                        input int want_lat, input logic [31:0] want_q,
                        input logic [1:0] want_exc, input logic want_flag);
    int lat;
    bus.a = a;
    bus.b = b;
    bus.chk_valid = cv;
    bus.chk_result = cr;
    bus.chk_exception = ce;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, " busy_after_start"}, {31'd0, bus.busy}, 32'd1);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, want_lat);
    check({tag, " quotient"}, bus.quotient, want_q);
    check({tag, " exception"}, {30'd0, bus.exception}, {30'd0, want_exc});
    check({tag, " exc_flag"}, {31'd0, bus.exc_flag}, {31'd0, want_flag});
    check({tag, " busy_in_done"}, {31'd0, bus.busy}, 32'd1);
    tick();
    check({tag, " done_cleared"}, {31'd0, bus.done}, 32'd0);
    check({tag, " busy_cleared"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.chk_valid = 1'b0;
    bus.chk_result = '0;
    bus.chk_exception = 2'b00;
    tick();
    tick();
    tick();
    reset = 1'b0;
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset quotient", bus.quotient, 32'd0);
    check("reset exception", {30'd0, bus.exception}, 32'd0);
    check("reset exc_flag", {31'd0, bus.exc_flag}, 32'd0);
    check("reset state", {30'd0, dbg_state}, {30'd0, IDLE});
    tick();

    run_op("6/2",    32'h40C00000, 32'h40000000, 1'b1, 32'h0, 2'b00, 29, 32'h40400000, 2'b00, 1'b0);
    run_op("-1/3",   32'hBF800000, 32'h40400000, 1'b1, 32'h0, 2'b00, 29, 32'hBEAAAAAB, 2'b00, 1'b0);
    run_op("1/1",    32'h3F800000, 32'h3F800000, 1'b1, 32'h0, 2'b00, 29, 32'h3F800000, 2'b00, 1'b0);
    run_op("-6/2",   32'hC0C00000, 32'h40000000, 1'b1, 32'h0, 2'b00, 29, 32'hC0400000, 2'b00, 1'b0);
    run_op("1/5",    32'h3F800000, 32'h40A00000, 1'b1, 32'h0, 2'b00, 29, 32'h3E4CCCCD, 2'b00, 1'b0);
    run_op("10/3",   32'h41200000, 32'h40400000, 1'b1, 32'h0, 2'b00, 29, 32'h40555555, 2'b00, 1'b0);
    run_op("special_inv", 32'h7FC00000, 32'h7FC00000, 1'b0, 32'hFFC00000, 2'b11, 1, 32'hFFC00000, 2'b11, 1'b1);
    run_op("special_divz", 32'h3F800000, 32'h00000000, 1'b0, 32'h7F800000, 2'b00, 1, 32'h7F800000, 2'b00, 1'b1);
    run_op("overflow",  32'h7F000000, 32'h00800000, 1'b1, 32'h0, 2'b00, 29, 32'h7F800000, 2'b01, 1'b1);
    run_op("underflow", 32'h00800000, 32'h7F000000, 1'b1, 32'h0, 2'b00, 29, 32'h00000000, 2'b10, 1'b1);
    run_op("denorm_a",  32'h00400000, 32'hC0000000, 1'b1, 32'h0, 2'b00, 1, 32'h80000000, 2'b00, 1'b0);
    run_op("denorm_b",  32'h3F800000, 32'h00000001, 1'b1, 32'h0, 2'b00, 1, 32'hFFC00000, 2'b00, 1'b1);

    // Start held through the done cycle of a special-path result must not relaunch.
    bus.a = 32'h0;
    bus.b = 32'h0;
    bus.chk_valid = 1'b0;
    bus.chk_result = 32'h12345678;
    bus.chk_exception = 2'b11;
    bus.start = 1'b1;
    tick();
    check("held_start first done", {31'd0, bus.done}, 32'd1);
    check("held_start quotient", bus.quotient, 32'h12345678);
    tick();
    bus.start = 1'b0;
    check("held_start no second done", {31'd0, bus.done}, 32'd0);
    check("held_start busy low", {31'd0, bus.busy}, 32'd0);
    tick();

    // Mid-operation reset: start at T, reset sampled at T+10, restart at T+12, stray start at T+15.
    bus.a = 32'h40C00000;
    bus.b = 32'h40000000;
    bus.chk_valid = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    early_done = 0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (bus.done !== 1'b0) early_done++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy T+11", {31'd0, bus.busy}, 32'd0);
    check("abort state T+11", {30'd0, dbg_state}, {30'd0, IDLE});
    for (int c = 11; c <= 40; c++) begin
      if (c == 12 || c == 15) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      if (c < 40 && bus.done !== 1'b0) early_done++;
    end
    check("abort no early done", early_done, 0);
    check("restart done T+41", {31'd0, bus.done}, 32'd1);
    check("restart quotient", bus.quotient, 32'h40400000);
    check("restart exc_flag", {31'd0, bus.exc_flag}, 32'd0);
    tick();
    check("restart busy T+42", {31'd0, bus.busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
